// File: rtl/mem_dual_port_arbiter.sv
// mem_dual_port_arbiter
// MEM-stage arbiter sharing one single-port synchronous data memory between the
// two issue slots of the dual-issue core. Dual accesses are serialized (slot1
// first, then slot2) with a one-cycle front-end stall; load data is routed to WB
// one cycle after the MEM cycle that completes the pair.
// Optional feature: define STORE_LOAD_BYPASS_EN to forward slot1 store data to a
// same-word slot2 load without stalling.
module mem_dual_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadEn_inst1_Mem,
    input  logic              MemWriteEn_inst1_Mem,
    input  logic [31:0]       AluOutMem_inst1,
    input  logic [DATA_W-1:0] ReadData2Mem_inst1,
    input  logic              MemReadEn_inst2_Mem,
    input  logic              MemWriteEn_inst2_Mem,
    input  logic [31:0]       AluOutMem_inst2,
    input  logic [DATA_W-1:0] ReadData2Mem_inst2,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_Mem,
    output logic [DATA_W-1:0] ReadData_inst1_WB,
    output logic [DATA_W-1:0] ReadData_inst2_WB
);

    typedef enum logic {IDLE, SECOND} state_t;
    typedef enum logic [1:0] {SRC1_NONE, SRC1_MEM, SRC1_HOLD} src1_t;
    typedef enum logic [1:0] {SRC2_NONE, SRC2_MEM, SRC2_BYP} src2_t;

    state_t            state_q, state_d;
    src1_t             src1_q, src1_d;
    src2_t             src2_q, src2_d;
    logic [DATA_W-1:0] hold1_q, hold1_d;
    logic [DATA_W-1:0] byp_q, byp_d;

    // A slot asserting both enables counts as a store, never as a load.
    logic st1, ld1, acc1, st2, ld2, acc2;
    logic [ADDR_W-1:0] waddr1, waddr2;
    logic issue, sel2, byp_hit;
    logic unused_addr_bits;

    assign st1  = MemWriteEn_inst1_Mem;
    assign ld1  = MemReadEn_inst1_Mem & ~MemWriteEn_inst1_Mem;
    assign acc1 = MemReadEn_inst1_Mem | MemWriteEn_inst1_Mem;
    assign st2  = MemWriteEn_inst2_Mem;
    assign ld2  = MemReadEn_inst2_Mem & ~MemWriteEn_inst2_Mem;
    assign acc2 = MemReadEn_inst2_Mem | MemWriteEn_inst2_Mem;

    assign waddr1 = AluOutMem_inst1[ADDR_W+1:2];
    assign waddr2 = AluOutMem_inst2[ADDR_W+1:2];
    assign unused_addr_bits = ^{AluOutMem_inst1[31:ADDR_W+2], AluOutMem_inst1[1:0],
                                AluOutMem_inst2[31:ADDR_W+2], AluOutMem_inst2[1:0]};

`ifdef STORE_LOAD_BYPASS_EN
    assign byp_hit = st1 & ld2 & (waddr1 == waddr2);
`else
    assign byp_hit = 1'b0;
`endif

    // Next-state logic: pick which slot owns the memory port this cycle and
    // where each slot's WB data will come from next cycle.
    always_comb begin
        state_d   = state_q;
        src1_d    = SRC1_NONE;
        src2_d    = SRC2_NONE;
        hold1_d   = hold1_q;
        byp_d     = byp_q;
        issue     = 1'b0;
        sel2      = 1'b0;
        stall_Mem = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (acc1 && acc2) begin
                        issue = 1'b1;
                        if (byp_hit) begin
                            byp_d  = ReadData2Mem_inst1;
                            src2_d = SRC2_BYP;
                        end else begin
                            stall_Mem = 1'b1;
                            state_d   = SECOND;
                        end
                    end else if (acc1) begin
                        issue = 1'b1;
                        if (ld1) src1_d = SRC1_MEM;
                    end else if (acc2) begin
                        issue = 1'b1;
                        sel2  = 1'b1;
                        if (ld2) src2_d = SRC2_MEM;
                    end
                end
                SECOND: begin
                    // mem_rdata now carries slot1's load issued last cycle.
                    issue   = acc2;
                    sel2    = 1'b1;
                    hold1_d = mem_rdata;
                    src1_d  = ld1 ? SRC1_HOLD : SRC1_NONE;
                    src2_d  = ld2 ? SRC2_MEM : SRC2_NONE;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Memory port drive from the selected slot.
    always_comb begin
        mem_addr  = sel2 ? waddr2 : waddr1;
        mem_wdata = sel2 ? ReadData2Mem_inst2 : ReadData2Mem_inst1;
        mem_we    = issue & (sel2 ? st2 : st1);
        mem_re    = issue & (sel2 ? ld2 : ld1);
    end

    // State, WB source selectors and held data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src1_q  <= SRC1_NONE;
            src2_q  <= SRC2_NONE;
            hold1_q <= '0;
            byp_q   <= '0;
        end else begin
            state_q <= state_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            hold1_q <= hold1_d;
            byp_q   <= byp_d;
        end
    end

    // WB load data mux on the registered source selectors.
    always_comb begin
        ReadData_inst1_WB = '0;
        ReadData_inst2_WB = '0;
        case (src1_q)
            SRC1_MEM:  ReadData_inst1_WB = mem_rdata;
            SRC1_HOLD: ReadData_inst1_WB = hold1_q;
            default:   ReadData_inst1_WB = '0;
        endcase
        case (src2_q)
            SRC2_MEM: ReadData_inst2_WB = mem_rdata;
            SRC2_BYP: ReadData_inst2_WB = byp_q;
            default:  ReadData_inst2_WB = '0;
        endcase
    end

endmodule

// File: doc/mem_dual_port_arbiter.md
Name: mem_dual_port_arbiter

Overview:
- MEM-stage consumer of both EX/MEM slot registers (inst1 and inst2) in the dual-issue core.
- Shares one single-port synchronous data memory between the two slots.
- When both slots access memory in the same cycle, it serializes them (inst1 first, then inst2) and stalls the front of the pipeline for one cycle.
- Routes load data to the WB stage per slot.

Parameters:
- ADDR_W, 8, data-memory word-address width; word address = AluOut[ADDR_W+1:2]
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- MemReadEn_inst1_Mem  in  1  slot1 load request
- MemWriteEn_inst1_Mem  in  1  slot1 store request
- AluOutMem_inst1  in  32  slot1 byte address
- ReadData2Mem_inst1  in  DATA_W  slot1 store data
- MemReadEn_inst2_Mem  in  1  slot2 load request
- MemWriteEn_inst2_Mem  in  1  slot2 store request
- AluOutMem_inst2  in  32  slot2 byte address
- ReadData2Mem_inst2  in  DATA_W  slot2 store data
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address
- stall_Mem  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; MEM/WB takes a bubble
- ReadData_inst1_WB  out  DATA_W  slot1 load data in WB
- ReadData_inst2_WB  out  DATA_W  slot2 load data in WB

Behaviour:
- Definitions: acc1 = MemReadEn_inst1_Mem | MemWriteEn_inst1_Mem; acc2 likewise for slot2. Requests hold stable while stall_Mem=1, because EX/MEM is frozen.
- FSM states: IDLE, SECOND. Registers: state, hold1_q (DATA_W), src1_q in {NONE, MEM, HOLD}, src2_q in {NONE, MEM, BYP}, byp_q.
- IDLE, neither slot accesses: mem_we=mem_re=0; stall_Mem=0; next src1/src2 = NONE.
- IDLE, exactly one slot accesses: drive that slot's addr/wdata/we/re combinationally; stall_Mem=0; stay IDLE. Next src for that slot = MEM if it is a load, else NONE.
- IDLE, both slots access: drive the slot1 access; stall_Mem=1; go to SECOND. Next src1=src2=NONE (WB holds a bubble).
- SECOND: drive the slot2 access; capture mem_rdata into hold1_q (slot1 load data); stall_Mem=0; go to IDLE. Next src1 = HOLD if slot1 is a load else NONE; next src2 = MEM if slot2 is a load else NONE.
- Outputs are a combinational mux on registered src: NONE→0, MEM→mem_rdata, HOLD→hold1_q, BYP→byp_q.
- Load data therefore reaches WB exactly one cycle after the MEM cycle that completes the instruction pair.
- Program order is preserved:
  - Same-address slot1 store followed by slot2 load: slot2 reads the stored value.
  - Both slots store to the same address: slot2's data is final.
- A slot asserting both MemReadEn and MemWriteEn is treated as a store; src stays NONE.
- Reset (synchronous): state=IDLE, hold1_q=0, byp_q=0, src1_q=src2_q=NONE. While reset=1, mem_we=mem_re=0 and stall_Mem=0.
- Reset asserted in SECOND: the pending slot2 access is dropped, with no memory write.
- Address bits above ADDR_W+1 and bits [1:0] are ignored; no wrap check.

Optional Feature:
- Macro: STORE_LOAD_BYPASS_EN.
- Defined: in IDLE, if slot1 stores and slot2 loads the same word address, there is no stall and no SECOND state. The slot1 write is issued, byp_q <= ReadData2Mem_inst1, and next src2 = BYP.
- Undefined: this case is serialized like any other dual access (1-cycle stall).

Test Plan:
- Slot1 load addr 0x10, mem[4]=0xDEADBEEF, slot2 idle → mem_addr=4, mem_re=1, stall_Mem=0; next cycle ReadData_inst1_WB=0xDEADBEEF, ReadData_inst2_WB=0.
- Both load: slot1 0x08 (mem[2]=0x11), slot2 0x0C (mem[3]=0x22) → cycle0 addr=2, stall_Mem=1; cycle1 addr=3, stall_Mem=0; cycle2 inst1=0x11, inst2=0x22.
- Slot1 store 0x55 to 0x20, slot2 load 0x20 (macro off) → stall 1 cycle, write then read addr 8; WB inst2=0x55. Macro on → stall_Mem=0, single write, WB inst2=0x55.
- Both store to 0x04, slot1 0xAA, slot2 0xBB → two writes to addr 1 in order; subsequent load of 0x04 returns 0xBB.
- Dual load, reset=1 in the SECOND cycle → mem_re=0 that cycle, stall_Mem=0; next cycle both WB outputs=0, state IDLE.
- Back-to-back dual accesses on consecutive instruction pairs → each pair costs exactly one stall cycle; WB data correct for both pairs.
